spi_reg_bridge: RTL and testbench

Command/register-file stage directly downstream of the SPI slave core. It consumes received bytes (byte + one-clock valid pulse), parses them into CS-framed read/write transactions, and maintains a small register file. It returns the transmit byte and load strobe that the slave shifts out on MISO. Register 0 is exported to drive the board LEDs; the top register is a read-only status input.

---
 rtl/spi_reg_bridge.sv | 156 +++++++++++++++
 tb/tb_spi_reg_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: parses CS-framed command/data bytes from the SPI slave core
// into register-file reads and writes, and feeds the slave its transmit bytes.
// The top register address reads back status_in and is not writable.
module spi_reg_bridge #(
    parameter int          ADDR_W   = 4,
    parameter logic [7:0]  SIG_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    input  logic [7:0]        status_in,
    output logic [7:0]        reg0_out,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_err,
    output logic [7:0]        byte_cnt
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_cs_meta;
    logic              r_cs_s;
    logic              r_cs_d;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_rx_acc;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;
    logic [7:0]        r_regs [NUM_REGS];

    logic [7:0]        r_tx_byte;
    logic              r_tx_load;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_frame_err;
    logic [7:0]        r_byte_cnt;

    // Two-flop CS synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
            r_cs_d    <= 1'b1;
        end else begin
            r_cs_meta <= spi_cs_n;
            r_cs_s    <= r_cs_meta;
            r_cs_d    <= r_cs_s;
        end
    end

    assign w_cs_fall = r_cs_d & ~r_cs_s;
    assign w_cs_rise = ~r_cs_d & r_cs_s;
    // A byte arriving on the CS rise cycle sees r_cs_s=1 and is dropped here
    assign w_rx_acc  = rx_valid & ~r_cs_s & (r_state != S_IDLE);

    // Read address/data for the byte to load next: the command's address in
    // CMD, the post-increment address in RD, so tx_load lands 1 clk after rx_valid
    always_comb begin
        w_rd_addr = (r_state == S_CMD) ? rx_byte[ADDR_W-1:0] : r_addr + ADDR_W'(1);
        w_rd_data = (w_rd_addr == TOP_ADDR) ? status_in : r_regs[w_rd_addr];
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode: CS rise aborts from any state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_next = S_CMD;
            S_CMD:   if (w_rx_acc)  w_next = rx_byte[7] ? S_WR : S_RD;
            default: w_next = r_state;
        endcase
        if (w_cs_rise) w_next = S_IDLE;
    end

    // Datapath: register file, transmit byte, strobes, error flag, byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i[ADDR_W-1:0]] <= '0;
            r_addr      <= '0;
            r_tx_byte   <= '0;
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;
            if (r_state == S_IDLE && w_cs_fall) begin
                r_tx_byte   <= SIG_BYTE;
                r_tx_load   <= 1'b1;
                r_byte_cnt  <= '0;
                r_frame_err <= 1'b0;
            end
            if (w_rx_acc) begin
                if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
                case (r_state)
                    S_CMD: begin
                        r_addr <= rx_byte[ADDR_W-1:0];
                        if (!rx_byte[7]) begin
                            r_tx_byte <= w_rd_data;
                            r_tx_load <= 1'b1;
                        end
                    end
                    S_WR: begin
                        if (r_addr == TOP_ADDR) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_regs[r_addr] <= rx_byte;
                            r_wr_strobe    <= 1'b1;
                            r_wr_addr      <= r_addr;
                        end
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    S_RD: begin
                        r_addr    <= w_rd_addr;
                        r_tx_byte <= w_rd_data;
                        r_tx_load <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_load   = r_tx_load;
    assign reg0_out  = r_regs[0];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed frames from the test plan followed by
// random frames, all compared against a transaction-level register model.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_cs_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] status_in;
    logic [7:0] reg0_out;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic       frame_err;
    logic [7:0] byte_cnt;

    always #5 clk = ~clk;

    spi_reg_bridge #(.ADDR_W(4), .SIG_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs_n  (spi_cs_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_load   (tx_load),
        .status_in (status_in),
        .reg0_out  (reg0_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err),
        .byte_cnt  (byte_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed and expected transmit loads / write addresses
    logic [7:0] tx_obs[$];
    logic [7:0] tx_exp[$];
    logic [3:0] wa_obs[$];
    logic [3:0] wa_exp[$];

    // Reference model: register contents plus frame-level bookkeeping
    logic [7:0] m_regs [16];
    int         m_mode;      // 0 idle, 1 awaiting command, 2 writing, 3 reading
    logic [3:0] m_addr;
    int         m_cnt;
    logic       m_ferr;
    logic       m_cs;

    always @(negedge clk) begin
        if (tx_load)   tx_obs.push_back(tx_byte);
        if (wr_strobe) wa_obs.push_back(wr_addr);
    end

    function automatic logic [7:0] m_rd(input logic [3:0] a);
        return (a == 4'hF) ? status_in : m_regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_mode = 0; m_addr = 4'h0; m_cnt = 0; m_ferr = 1'b0; m_cs = 1'b1;
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        m_cs = 1'b0; m_mode = 1; m_cnt = 0; m_ferr = 1'b0;
        tx_exp.push_back(8'hA5);
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        spi_cs_n = 1'b1;
        m_cs = 1'b1; m_mode = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_cs || m_mode == 0) return;
        if (m_cnt < 255) m_cnt++;
        case (m_mode)
            1: begin
                m_addr = b[3:0];
                if (b[7]) m_mode = 2;
                else begin
                    m_mode = 3;
                    tx_exp.push_back(m_rd(m_addr));
                end
            end
            2: begin
                if (m_addr == 4'hF) m_ferr = 1'b1;
                else begin
                    m_regs[m_addr] = b;
                    wa_exp.push_back(m_addr);
                end
                m_addr = m_addr + 4'd1;
            end
            default: begin
                m_addr = m_addr + 4'd1;
                tx_exp.push_back(m_rd(m_addr));
            end
        endcase
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        model_byte(b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Raise CS so that the synchronised rise coincides with this byte's rx_valid
    task automatic send_abort(input logic [7:0] b);
        @(negedge clk);
        spi_cs_n = 1'b1;
        m_cs = 1'b1; m_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int n;
        #1;
        chk({tag, ".reg0"},     reg0_out,  m_regs[0]);
        chk({tag, ".ferr"},     frame_err, m_ferr);
        chk({tag, ".cnt"},      byte_cnt,  m_cnt);
        chk({tag, ".tx_n"},     tx_obs.size(), tx_exp.size());
        n = (tx_obs.size() < tx_exp.size()) ? tx_obs.size() : tx_exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.tx%0d", tag, i), tx_obs[i], tx_exp[i]);
        chk({tag, ".wr_n"},     wa_obs.size(), wa_exp.size());
        n = (wa_obs.size() < wa_exp.size()) ? wa_obs.size() : wa_exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.wa%0d", tag, i), wa_obs[i], wa_exp[i]);
        tx_obs.delete(); tx_exp.delete(); wa_obs.delete(); wa_exp.delete();
    endtask

    initial begin
        logic [7:0] cmd;
        int         nb;

        rst_n = 1'b0; spi_cs_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; status_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst.tx_byte", tx_byte, 8'h00);
        chk("rst.tx_load", tx_load, 1'b0);
        chk("rst.reg0",    reg0_out, 8'h00);
        chk("rst.wr_addr", wr_addr, 4'h0);
        chk("rst.ferr",    frame_err, 1'b0);
        chk("rst.cnt",     byte_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write burst to registers 0 and 1
        cs_low(); send(8'h80, 15); send(8'h3C, 15); send(8'h55, 15); cs_high();
        chk("wburst.reg0_c", reg0_out, 8'h3C);
        chk("wburst.cnt_c",  byte_cnt, 8'd3);
        check_state("wburst");

        // Read burst from register 0
        cs_low(); send(8'h00, 15); send(8'hFF, 15); send(8'hFF, 15); cs_high();
        chk("rburst.tx1_c", (tx_obs.size() > 1) ? tx_obs[1] : 8'hxx, 8'h3C);
        check_state("rburst");

        // Read from the status address, wrapping to register 0 and 1
        status_in = 8'h7E;
        cs_low(); send(8'h0F, 15); send(8'hFF, 15); send(8'hFF, 15); cs_high();
        check_state("wrap_rd");

        // Write to the read-only address: flagged, then wraps to register 0
        cs_low(); send(8'h8F, 15); send(8'h11, 15);
        #1 chk("illegal.ferr_c", frame_err, 1'b1);
        cs_high();
        check_state("illegal");
        cs_low();
        #1 chk("illegal.ferr_clr", frame_err, 1'b0);
        cs_high();
        check_state("ferr_clr");

        // CS rises on the same cycle as a write data byte
        cs_low(); send(8'h82, 15); send_abort(8'h99);
        check_state("abort");

        // Bytes while CS is high are ignored
        send(8'h80, 15); send(8'h12, 15);
        check_state("cs_high");

        // Reset in the middle of a write frame
        cs_low(); send(8'h81, 15); send(8'h22, 15);
        check_state("pre_rst");
        @(negedge clk);
        rst_n = 1'b0; spi_cs_n = 1'b1;
        model_reset();
        #1;
        chk("mrst.reg0",    reg0_out, 8'h00);
        chk("mrst.tx_load", tx_load, 1'b0);
        chk("mrst.cnt",     byte_cnt, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tx_obs.delete(); wa_obs.delete();
        cs_low(); send(8'h80, 15); send(8'h5A, 15); cs_high();
        chk("post_rst.reg0_c", reg0_out, 8'h5A);
        check_state("post_rst");

        // Random frames
        for (int f = 0; f < 24; f++) begin
            status_in = 8'($urandom);
            cmd = 8'($urandom);
            nb  = $urandom_range(1, 6);
            cs_low();
            send(cmd, 15);
            for (int k = 0; k < nb; k++) send(8'($urandom), 15);
            cs_high();
            check_state($sformatf("rnd%0d", f));
        end

        // Byte counter saturation
        cs_low();
        send(8'h00, 4);
        for (int k = 0; k < 259; k++) send(8'hFF, 4);
        #1 chk("sat.cnt_c", byte_cnt, 8'd255);
        cs_high();
        check_state("sat");

        // Full readback of the register file
        cs_low();
        send(8'h00, 15);
        for (int k = 0; k < 15; k++) send(8'hFF, 15);
        cs_high();
        check_state("sweep");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
